// File: rtl/arbiter_weighted_round_robin_if.sv
// Request/grant bundle for arbiter_weighted_round_robin.
// The master modport is the requester side and the slave modport is the arbiter side.
interface arbiter_weighted_round_robin_if #(
  parameter int CLIENTS  = 4,
  parameter int WEIGHT_W = 4
);
  localparam int ID_W = $clog2(CLIENTS);

  logic                        i_block_arb;
  logic [CLIENTS-1:0]          i_req;
  logic [CLIENTS*WEIGHT_W-1:0] i_weight;
  logic [CLIENTS-1:0]          i_gnt_ack;
  logic [CLIENTS-1:0]          o_gnt;
  logic [ID_W-1:0]             o_gnt_id;
  logic                        o_gnt_valid;

  modport master (
    output i_block_arb, i_req, i_weight, i_gnt_ack,
    input  o_gnt, o_gnt_id, o_gnt_valid
  );

  modport slave (
    input  i_block_arb, i_req, i_weight, i_gnt_ack,
    output o_gnt, o_gnt_id, o_gnt_valid
  );
endinterface

// File: rtl/arbiter_weighted_round_robin.sv
// Weighted round-robin arbiter: per-client credits reloaded from i_weight once an epoch runs dry.
// Define ARB_WRR_ACK_EN to hold each grant until its owner acknowledges it.
module arbiter_weighted_round_robin #(
  parameter int CLIENTS  = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  arbiter_weighted_round_robin_if.slave bus
);
  localparam int                  ID_W       = $clog2(CLIENTS);
  localparam logic [ID_W-1:0]     LAST_INIT  = ID_W'(CLIENTS - 1);
  localparam logic [WEIGHT_W-1:0] CREDIT_ONE = WEIGHT_W'(1);

  logic [WEIGHT_W-1:0] r_credit [CLIENTS];
  logic [ID_W-1:0]     r_last;
  logic [CLIENTS-1:0]  r_gnt;
  logic [ID_W-1:0]     r_gnt_id;
  logic                r_gnt_valid;

  logic [WEIGHT_W-1:0] w_weight [CLIENTS];
  logic [CLIENTS-1:0]  w_req_post;
  logic [CLIENTS-1:0]  w_elig;
  logic [CLIENTS-1:0]  w_cand;
  logic [CLIENTS-1:0]  w_win_onehot;
  logic [ID_W-1:0]     w_win_id;
  logic                w_win_valid;
  logic                w_reload;
  logic                w_arb_en;
  logic                w_do_arb;

  // A zero weight still earns one grant per epoch.
  always_comb begin
    for (int i = 0; i < CLIENTS; i++) begin
      w_weight[i] = (bus.i_weight[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                    CREDIT_ONE : bus.i_weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  always_comb begin
    w_req_post = bus.i_block_arb ? '0 : bus.i_req;
    for (int i = 0; i < CLIENTS; i++) begin
      w_elig[i] = w_req_post[i] && (r_credit[i] != '0);
    end
    w_reload = (w_req_post != '0) && (w_elig == '0);
    w_cand   = w_reload ? w_req_post : w_elig;
  end

  always_comb begin : p_search
    int v_idx;
    v_idx       = 0;
    w_win_valid = 1'b0;
    w_win_id    = '0;
    for (int k = 1; k <= CLIENTS; k++) begin
      v_idx = (int'(r_last) + k) % CLIENTS;
      if (!w_win_valid && w_cand[v_idx]) begin
        w_win_valid = 1'b1;
        w_win_id    = v_idx[ID_W-1:0];
      end
    end
    w_win_onehot = w_win_valid ? (CLIENTS'(1) << w_win_id) : '0;
  end

  assign w_do_arb = w_arb_en && w_win_valid;

  // On a reload the winner is charged against its freshly loaded budget.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < CLIENTS; i++) begin
        r_credit[i] <= '0;
      end
      r_last <= LAST_INIT;
    end else if (w_do_arb) begin
      for (int i = 0; i < CLIENTS; i++) begin
        if (w_reload) begin
          r_credit[i] <= w_win_onehot[i] ? (w_weight[i] - CREDIT_ONE) : w_weight[i];
        end else if (w_win_onehot[i] && (r_credit[i] != '0)) begin
          r_credit[i] <= r_credit[i] - CREDIT_ONE;
        end
      end
      r_last <= w_win_id;
    end
  end

`ifdef ARB_WRR_ACK_EN
  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t r_state;

  // Only the current owner's ack bit can end a grant.
  assign w_arb_en = (r_state == S_IDLE) || bus.i_gnt_ack[r_gnt_id];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_valid) begin
            r_gnt       <= w_win_onehot;
            r_gnt_id    <= w_win_id;
            r_gnt_valid <= 1'b1;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (bus.i_gnt_ack[r_gnt_id]) begin
            if (w_win_valid) begin
              r_gnt       <= w_win_onehot;
              r_gnt_id    <= w_win_id;
              r_gnt_valid <= 1'b1;
            end else begin
              r_gnt       <= '0;
              r_gnt_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        default: begin
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end
`else
  logic w_unused_ack;

  assign w_arb_en     = 1'b1;
  assign w_unused_ack = ^bus.i_gnt_ack;

  // Without the handshake every grant is a single-cycle pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      r_gnt       <= w_win_onehot;
      r_gnt_valid <= w_win_valid;
      if (w_win_valid) begin
        r_gnt_id <= w_win_id;
      end
    end
  end
`endif

  assign bus.o_gnt       = r_gnt;
  assign bus.o_gnt_id    = r_gnt_id;
  assign bus.o_gnt_valid = r_gnt_valid;

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(r_gnt));
  a_valid_tracks_gnt : assert property (@(posedge i_clk) disable iff (i_rst) r_gnt_valid == (r_gnt != '0));
`endif
endmodule

// File: tb/tb_arbiter_weighted_round_robin.sv
// Self-checking bench for arbiter_weighted_round_robin: a credit/epoch model checked every cycle
// plus hand-computed grant sequences. Build with or without ARB_WRR_ACK_EN.
module tb_arbiter_weighted_round_robin;
  localparam int CLIENTS  = 4;
  localparam int WEIGHT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  arbiter_weighted_round_robin_if #(.CLIENTS(CLIENTS), .WEIGHT_W(WEIGHT_W)) bus ();

  arbiter_weighted_round_robin #(.CLIENTS(CLIENTS), .WEIGHT_W(WEIGHT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkOn     = 1'b0;

  // Model: credits per client, last winner, and the grant currently expected on the outputs.
  int mCredit [CLIENTS];
  int mLast;
  bit mValid;
  int mId;

  function automatic int weightOf(int i);
    int w;
    w = int'(bus.i_weight[i*WEIGHT_W +: WEIGHT_W]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < CLIENTS; i++) mCredit[i] = 0;
    mLast  = CLIENTS - 1;
    mValid = 1'b0;
    mId    = 0;
  endtask

  task automatic modelStep();
    logic [CLIENTS-1:0] reqP;
    bit anyElig;
    bit arb;
    int winner;
    reqP = bus.i_block_arb ? '0 : bus.i_req;
`ifdef ARB_WRR_ACK_EN
    arb = !mValid || bus.i_gnt_ack[mId];
`else
    arb = 1'b1;
`endif
    if (!arb) return;
    if (reqP == '0) begin
      mValid = 1'b0;
      return;
    end
    anyElig = 1'b0;
    for (int i = 0; i < CLIENTS; i++) if (reqP[i] && mCredit[i] > 0) anyElig = 1'b1;
    if (!anyElig) for (int i = 0; i < CLIENTS; i++) mCredit[i] = weightOf(i);
    winner = -1;
    for (int k = 1; k <= CLIENTS; k++) begin
      int j;
      j = (mLast + k) % CLIENTS;
      if (winner < 0 && reqP[j] && mCredit[j] > 0) winner = j;
    end
    mCredit[winner] = mCredit[winner] - 1;
    mLast  = winner;
    mValid = 1'b1;
    mId    = winner;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else     modelStep();
  end

  // Compare the DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (checkOn && !rst) begin
      logic [CLIENTS-1:0] expG;
      expG = mValid ? (CLIENTS'(1) << mId) : '0;
      testsRun++;
      if (bus.o_gnt !== expG || bus.o_gnt_valid !== mValid ||
          (mValid && int'(bus.o_gnt_id) != mId)) begin
        testsFailed++;
        $display("[TB] FAIL model t=%0t: got gnt=%b id=%0d valid=%b, want gnt=%b id=%0d valid=%b",
                 $time, bus.o_gnt, bus.o_gnt_id, bus.o_gnt_valid, expG, mId, mValid);
      end
    end
  end

  task automatic applyStimulus(input logic [CLIENTS-1:0] req, input logic block,
                               input logic [CLIENTS-1:0] ack,
                               input logic [CLIENTS*WEIGHT_W-1:0] weights);
    bus.i_req       = req;
    bus.i_block_arb = block;
    bus.i_gnt_ack   = ack;
    bus.i_weight    = weights;
  endtask

  task automatic checkOutput(input string name, input logic [CLIENTS-1:0] expGnt);
    int expId;
    expId = 0;
    for (int i = 0; i < CLIENTS; i++) if (expGnt[i]) expId = i;
    testsRun++;
    if (bus.o_gnt !== expGnt || bus.o_gnt_valid !== (expGnt != '0) ||
        (expGnt != '0 && int'(bus.o_gnt_id) != expId)) begin
      testsFailed++;
      $display("[TB] FAIL %s: got gnt=%b id=%0d valid=%b, want gnt=%b id=%0d valid=%b",
               name, bus.o_gnt, bus.o_gnt_id, bus.o_gnt_valid, expGnt, expId, expGnt != '0);
    end
  endtask

  task automatic checkReset(input string name);
    testsRun++;
    if (bus.o_gnt !== '0 || bus.o_gnt_id !== '0 || bus.o_gnt_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s: got gnt=%b id=%0d valid=%b, want all zero",
               name, bus.o_gnt, bus.o_gnt_id, bus.o_gnt_valid);
    end
  endtask

  task automatic stepCheck(input string name, input logic [CLIENTS-1:0] expGnt);
    @(negedge clk);
    checkOutput(name, expGnt);
  endtask

  task automatic stepCheckIds(input string name, input int ids[$]);
    foreach (ids[n]) stepCheck($sformatf("%s[%0d]", name, n), CLIENTS'(1) << ids[n]);
  endtask

  // Enter reset on a falling edge, check the cleared outputs, release with the given stimulus.
  task automatic doReset(input logic [CLIENTS-1:0] req, input logic [CLIENTS*WEIGHT_W-1:0] weights);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus('0, 1'b0, '0, weights);
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;
    applyStimulus(req, 1'b0, '0, weights);
    checkOn = 1'b1;
  endtask

  initial begin
    applyStimulus('0, 1'b0, '0, '0);
    #1 rst = 1'b1;

`ifndef ARB_WRR_ACK_EN
    $display("[TB] pulse mode");
    doReset(4'b1111, 16'h1111);
    stepCheckIds("rr_equal", '{0, 1, 2, 3, 0});

    doReset(4'b1111, 16'h1113);
    stepCheckIds("weighted", '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0, 0});
    applyStimulus(4'b1111, 1'b1, '0, 16'h1113);
    stepCheck("blocked0", 4'b0000);
    stepCheck("blocked1", 4'b0000);
    applyStimulus(4'b1111, 1'b0, '0, 16'h1113);
    stepCheck("unblocked", 4'b0010);

    doReset(4'b1000, 16'h1111);
    repeat (4) stepCheck("single", 4'b1000);

    doReset(4'b0011, 16'h1111);
    stepCheck("wchg0", 4'b0001);
    applyStimulus(4'b0011, 1'b0, '0, 16'h1113);
    stepCheckIds("wchg", '{1, 0, 1, 0, 0, 1});

    doReset(4'b0001, 16'h1111);
    stepCheck("pre_async", 4'b0001);
`else
    $display("[TB] ack mode");
    doReset(4'b0110, 16'h1111);
    repeat (5) stepCheck("hold", 4'b0010);
    applyStimulus(4'b0110, 1'b0, 4'b0100, 16'h1111);
    stepCheck("wrong_ack", 4'b0010);
    applyStimulus(4'b0110, 1'b0, 4'b0010, 16'h1111);
    stepCheck("ack_next", 4'b0100);
    applyStimulus(4'b0110, 1'b0, '0, 16'h1111);
    stepCheck("hold2", 4'b0100);

    applyStimulus(4'b0110, 1'b1, 4'b0100, 16'h1111);
    stepCheck("ack_blocked", 4'b0000);
    applyStimulus(4'b0110, 1'b1, '0, 16'h1111);
    stepCheck("still_blocked", 4'b0000);
    applyStimulus(4'b0110, 1'b0, '0, 16'h1111);
    stepCheck("unblocked", 4'b0010);

    doReset(4'b0001, 16'h1111);
    stepCheck("pre_async", 4'b0001);
    stepCheck("pre_async_hold", 4'b0001);
`endif

    #2 rst = 1'b1;
    #1 checkReset("async_reset");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b0, '0, 16'h1111);
    stepCheck("post_async", 4'b0001);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
